// File: rtl/axi_burst_writer_if.sv
// Bundle of the job-control, stream and AXI4 write-channel signals of the
// burst writer. "master" is the writer side, "slave" is its environment
// (job controller, FIFO read port and memory).
interface axi_burst_writer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                    start;
   logic [ADDR_WIDTH-1:0]   base_addr;
   logic [CNT_WIDTH-1:0]    total_beats;
   logic                    busy;
   logic                    done;
   logic                    error;
   logic [DATA_WIDTH-1:0]   s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      input  start, base_addr, total_beats, s_data, s_valid,
             awready, wready, bresp, bvalid,
      output busy, done, error, s_ready, awaddr, awlen, awsize, awburst,
             awvalid, wdata, wstrb, wlast, wvalid, bready
   );

   modport slave (
      output start, base_addr, total_beats, s_data, s_valid,
             awready, wready, bresp, bvalid,
      input  busy, done, error, s_ready, awaddr, awlen, awsize, awburst,
             awvalid, wdata, wstrb, wlast, wvalid, bready
   );
endinterface

// File: rtl/axi_burst_writer.sv
// Drains a valid/ready word stream into memory as AXI4 INCR write bursts.
// One burst at a time: AW, then all W beats, then B, before the next AW.
// An error response ends the job after the burst in progress.
module axi_burst_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input logic clk,
   input logic rst,
   axi_burst_writer_if.master bus
);
   localparam int         BYTES = DATA_WIDTH / 8;
   localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [CNT_WIDTH-1:0]  remaining;
   logic [7:0]            len;
   logic [7:0]            beat;
   logic                  accept;
   logic                  w_hs;
   logic                  last_hs;
   logic                  b_hs;
   logic                  end_job;

   // AWLEN for the next burst: a full burst, or whatever is left if shorter.
   function automatic logic [7:0] burst_awlen(input logic [CNT_WIDTH-1:0] rem);
      if (32'(rem) >= 32'(BURST_LEN))
         return 8'(BURST_LEN - 1);
      else
         return 8'(rem) - 8'd1;
   endfunction

   // A START coinciding with DONE is refused: the job is still finishing.
   assign accept    = (state == IDLE) && bus.start && !bus.done;
   assign w_hs      = (state == DATA) && bus.s_valid && bus.wready;
   assign last_hs   = w_hs && (beat == len);
   assign b_hs      = (state == RESP) && bus.bvalid;
   assign end_job   = b_hs && ((bus.bresp != 2'b00) || bus.error || (remaining == '0));
   assign addr_next = addr + ADDR_WIDTH'((32'(len) + 32'd1) * BYTES);

   assign bus.awsize  = SIZE;
   assign bus.awburst = 2'b01;
   assign bus.wstrb   = '1;
   assign bus.wdata   = bus.s_data;

   // Stream-to-W pass-through, only open while a burst's data phase is active.
   always_comb begin
      bus.s_ready = (state == DATA) && bus.wready;
      bus.wvalid  = (state == DATA) && bus.s_valid;
      bus.wlast   = (state == DATA) && (beat == len);
   end

   // Control FSM and the registered AW / B / status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.error   <= 1'b0;
         bus.awvalid <= 1'b0;
         bus.awaddr  <= '0;
         bus.awlen   <= '0;
         bus.bready  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.error <= 1'b0;
                  if (bus.total_beats == '0) begin
                     bus.done <= 1'b1;
                  end else begin
                     state       <= ADDR;
                     bus.busy    <= 1'b1;
                     bus.awvalid <= 1'b1;
                     bus.awaddr  <= bus.base_addr;
                     bus.awlen   <= burst_awlen(bus.total_beats);
                  end
               end
            end
            ADDR: begin
               if (bus.awready) begin
                  bus.awvalid <= 1'b0;
                  state       <= DATA;
               end
            end
            DATA: begin
               if (last_hs) begin
                  state      <= RESP;
                  bus.bready <= 1'b1;
               end
            end
            RESP: begin
               if (bus.bvalid) begin
                  bus.bready <= 1'b0;
                  if (bus.bresp != 2'b00)
                     bus.error <= 1'b1;
                  if (end_job) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end else begin
                     state       <= ADDR;
                     bus.awvalid <= 1'b1;
                     bus.awaddr  <= addr_next;
                     bus.awlen   <= burst_awlen(remaining);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Job bookkeeping: burst address, beats left, and position within a burst.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr      <= bus.base_addr;
         remaining <= bus.total_beats;
      end
      if ((state == ADDR) && bus.awready) begin
         len  <= bus.awlen;
         beat <= 8'd0;
      end
      if (w_hs) begin
         beat      <= beat + 8'd1;
         remaining <= remaining - CNT_WIDTH'(1);
      end
      if (b_hs && !end_job)
         addr <= addr_next;
   end
endmodule

// File: tb/tb_axi_burst_writer.sv
// Bench for axi_burst_writer: table of jobs with hand-computed bursts and
// outcomes, plus hand sequences for reset behaviour.
module tb_axi_burst_writer;
   logic clk;
   logic rst;

   axi_burst_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();

   axi_burst_writer #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(16), .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      base;
      int               total;
      int               stall;
      int               err_burst;
      bit               noise;
      int               n_bursts;
      logic [2:0][31:0] aw_addr;
      logic [2:0][7:0]  aw_len;
      bit               exp_err;
      int               exp_left;
   } cfg_t;

   int          checks   = 0;
   int          failures = 0;
   cfg_t        jobs[9];
   cfg_t        cur;
   logic [31:0] fifo[$];
   logic [31:0] word_base;
   int          wr_cnt, aw_idx, b_idx, done_cnt, beat_in_burst, cur_len, cyc;
   int          cyc_start, cyc_first_awv, cyc_last_b, cyc_done;
   bit          b_pending, aw_hold, any_sready, any_awvalid, last_busy;
   bit          start_drv, rst_drv;
   logic [31:0] prev_awaddr;
   logic [7:0]  prev_awlen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic cfg_t mk(input logic [31:0] base, input int total, input int stall,
                               input int errb, input bit noise, input int nb,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                               input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                               input bit err, input int left);
      cfg_t c;
      c.base = base; c.total = total; c.stall = stall; c.err_burst = errb;
      c.noise = noise; c.n_bursts = nb;
      c.aw_addr[0] = a0; c.aw_addr[1] = a1; c.aw_addr[2] = a2;
      c.aw_len[0] = l0;  c.aw_len[1] = l1;  c.aw_len[2] = l2;
      c.exp_err = err; c.exp_left = left;
      return c;
   endfunction

   function automatic bit go();
      return $urandom_range(0, 99) >= cur.stall;
   endfunction

   // One clock: drive inputs after the falling edge, then observe the
   // handshakes that the next rising edge will complete.
   task automatic step();
      @(negedge clk);
      cyc++;
      rst         = rst_drv;
      bus.s_valid = (fifo.size() != 0) && go();
      bus.s_data  = (fifo.size() != 0) ? fifo[0] : 32'h0;
      bus.awready = go();
      bus.wready  = go();
      bus.bvalid  = b_pending && go();
      bus.bresp   = (b_idx == cur.err_burst) ? 2'b10 : 2'b00;
      if (start_drv) begin
         bus.start = 1'b1; bus.base_addr = cur.base; bus.total_beats = 16'(cur.total);
      end else begin
         bus.start = cur.noise && last_busy; bus.base_addr = 32'h9000; bus.total_beats = 16'd3;
      end
      #1;
      if (start_drv) cyc_start = cyc;
      if (bus.awvalid === 1'b1 && cyc_first_awv < 0) cyc_first_awv = cyc;
      if (bus.s_ready === 1'b1) any_sready = 1'b1;
      if (bus.awvalid === 1'b1) any_awvalid = 1'b1;
      if (aw_hold)
         chk("aw_stable", {bus.awvalid, bus.awaddr, bus.awlen}, {1'b1, prev_awaddr, prev_awlen});
      if (bus.awvalid === 1'b1 && bus.awready) begin
         if (aw_idx < cur.n_bursts) begin
            chk("awaddr", bus.awaddr, cur.aw_addr[aw_idx]);
            chk("awlen", bus.awlen, cur.aw_len[aw_idx]);
            cur_len = int'(cur.aw_len[aw_idx]);
         end else begin
            chk("aw_extra", aw_idx, cur.n_bursts);
            cur_len = int'(bus.awlen);
         end
         chk("aw_size_burst", {bus.awsize, bus.awburst}, {3'd2, 2'b01});
         beat_in_burst = 0;
         aw_idx++;
      end
      aw_hold     = (bus.awvalid === 1'b1) && !bus.awready;
      prev_awaddr = bus.awaddr;
      prev_awlen  = bus.awlen;
      if ((bus.s_valid && bus.s_ready) !== (bus.wvalid && bus.wready))
         chk("pop_eq_w", bus.s_valid && bus.s_ready, bus.wvalid && bus.wready);
      if (bus.wvalid === 1'b1 && bus.wready) begin
         chk("wdata", bus.wdata, word_base + 32'(wr_cnt));
         chk("wlast", bus.wlast, beat_in_burst == cur_len);
         chk("wstrb", bus.wstrb, 4'hF);
         if (bus.wlast === 1'b1) b_pending = 1'b1;
         beat_in_burst++;
         wr_cnt++;
         if (fifo.size() != 0) void'(fifo.pop_front());
      end
      if (bus.bvalid && bus.bready === 1'b1) begin
         b_pending  = 1'b0;
         b_idx++;
         cyc_last_b = cyc;
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         cyc_done = cyc;
      end
      last_busy = (bus.busy === 1'b1);
   endtask

   task automatic start_job(input cfg_t c, input int tag);
      cur = c;
      word_base = 32'(tag) << 16;
      fifo.delete();
      for (int k = 0; k < c.total; k++) fifo.push_back(word_base + 32'(k));
      wr_cnt = 0; aw_idx = 0; b_idx = 0; done_cnt = 0; beat_in_burst = 0; cur_len = 0;
      b_pending = 1'b0; any_sready = 1'b0; any_awvalid = 1'b0;
      cyc_first_awv = -1; cyc_last_b = -1; cyc_done = -1;
      start_drv = 1'b1;
      step();
      start_drv = 1'b0;
      step();
      chk("error_cleared", bus.error, 1'b0);
   endtask

   task automatic finish_job(input cfg_t c);
      for (int k = 0; k < 3000 && done_cnt == 0; k++) step();
      repeat (4) step();
      chk("n_aw", aw_idx, c.n_bursts);
      chk("n_words", wr_cnt, c.total - c.exp_left);
      chk("n_done", done_cnt, 1);
      chk("error", bus.error, c.exp_err);
      chk("fifo_left", fifo.size(), c.exp_left);
      chk("busy_end", bus.busy, 1'b0);
      if (c.total == 0) begin
         chk("done_lat0", cyc_done - cyc_start, 1);
         chk("no_awvalid", any_awvalid, 1'b0);
         chk("no_sready", any_sready, 1'b0);
      end else begin
         chk("aw_lat", cyc_first_awv - cyc_start, 1);
         chk("done_lat", cyc_done - cyc_last_b, 1);
      end
   endtask

   initial begin
      jobs[0] = mk(32'h1000, 16, 0, -1, 0, 1, 32'h1000, 0, 0, 8'd15, 0, 0, 0, 0);
      jobs[1] = mk(32'h1000, 40, 0, -1, 1, 3, 32'h1000, 32'h1040, 32'h1080, 8'd15, 8'd15, 8'd7, 0, 0);
      jobs[2] = mk(32'h2000, 40, 30, -1, 1, 3, 32'h2000, 32'h2040, 32'h2080, 8'd15, 8'd15, 8'd7, 0, 0);
      jobs[3] = mk(32'h3000, 40, 0, 0, 0, 1, 32'h3000, 0, 0, 8'd15, 0, 0, 1, 24);
      jobs[4] = mk(32'h0000, 5, 0, -1, 0, 1, 32'h0000, 0, 0, 8'd4, 0, 0, 0, 0);
      jobs[5] = mk(32'hFFFF_FFC0, 32, 20, -1, 0, 2, 32'hFFFF_FFC0, 32'h0, 0, 8'd15, 8'd15, 0, 0, 0);
      jobs[6] = mk(32'h4000, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      jobs[7] = mk(32'h5000, 17, 30, -1, 1, 2, 32'h5000, 32'h5040, 0, 8'd15, 8'd0, 0, 0, 0);
      jobs[8] = mk(32'h6000, 16, 30, 0, 0, 1, 32'h6000, 0, 0, 8'd15, 0, 0, 1, 0);

      cyc = 0; start_drv = 1'b0; rst_drv = 1'b1; aw_hold = 1'b0; last_busy = 1'b0;
      b_pending = 1'b0; b_idx = 0; aw_idx = 0; wr_cnt = 0; done_cnt = 0;
      cur = mk(32'h0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      bus.start = 1'b0; bus.base_addr = '0; bus.total_beats = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.awready = 1'b0; bus.wready = 1'b0;
      bus.bvalid = 1'b0; bus.bresp = 2'b00;

      // Reset values
      repeat (3) step();
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_error", bus.error, 1'b0);
      chk("rst_awvalid", bus.awvalid, 1'b0);
      chk("rst_awaddr", bus.awaddr, 32'h0);
      chk("rst_awlen", bus.awlen, 8'h0);
      chk("rst_bready", bus.bready, 1'b0);
      chk("rst_wvalid_wlast_sready", {bus.wvalid, bus.wlast, bus.s_ready}, 3'b000);
      rst_drv = 1'b0;
      step();

      for (int i = 0; i < 9; i++) begin
         start_job(jobs[i], i + 1);
         finish_job(jobs[i]);
      end

      // Reset in the middle of the data phase, then a normal job
      start_job(mk(32'h7000, 16, 0, -1, 0, 1, 32'h7000, 0, 0, 8'd15, 0, 0, 0, 0), 10);
      for (int k = 0; k < 200 && wr_cnt < 4; k++) step();
      chk("beats_before_rst", wr_cnt, 4);
      rst_drv = 1'b1;
      step();
      rst_drv = 1'b0;
      step();
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_wvalid", bus.wvalid, 1'b0);
      chk("mid_rst_awvalid", bus.awvalid, 1'b0);
      chk("mid_rst_sready", bus.s_ready, 1'b0);
      chk("mid_rst_bready", bus.bready, 1'b0);
      b_pending = 1'b0;
      start_job(jobs[1], 11);
      finish_job(jobs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
